// File: rtl/prediction_table_pkg.sv
// prediction_table_pkg: shared entry layout, init value, select codes and sweep FSM states.
// Rev 1.0
`default_nettype none

package prediction_table_pkg;

  localparam int TREND_W = 3;
  localparam logic [TREND_W-1:0] INIT_TREND = 3'd4;

  localparam logic [1:0] SEL_SP  = 2'b00;
  localparam logic [1:0] SEL_LHP = 2'b01;
  localparam logic [1:0] SEL_GHP = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic int entry_w(input int stat_w);
    return TREND_W + stat_w;
  endfunction

  // Entry layout is {trend, stat}; stat starts at the midpoint of its range.
  function automatic logic [63:0] init_entry(input int stat_w);
    return (64'(INIT_TREND) << stat_w) | (64'd1 << (stat_w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/prediction_table_bank.sv
// pred_bank: register-file bank with two prioritised write ports, one bypassed read index.
// Rev 1.0
`default_nettype none

module pred_bank #(
  parameter int DEPTH = 2,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int ENTRY_W = 8,
  parameter logic [ENTRY_W-1:0] INIT_ENTRY = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en1,
  input  logic [IDX_W-1:0]   wr_idx1,
  input  logic [ENTRY_W-1:0] wr_data1,
  input  logic               wr_en2,
  input  logic [IDX_W-1:0]   wr_idx2,
  input  logic [ENTRY_W-1:0] wr_data2,
  input  logic               clr_one,
  input  logic [IDX_W-1:0]   clr_idx,
  input  logic               clr_all,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               port2_dropped;

  assign port2_dropped = wr_en1 && (wr_idx1 == wr_idx2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT_ENTRY;
      end
    end else begin
      if (clr_all) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= INIT_ENTRY;
        end
      end
      if (clr_one) begin
        mem[clr_idx] <= INIT_ENTRY;
      end
      if (wr_en2 && !port2_dropped) begin
        mem[wr_idx2] <= wr_data2;
      end
      if (wr_en1) begin
        mem[wr_idx1] <= wr_data1;
      end
    end
  end

  // Same-cycle writes to the read index are forwarded, port 1 first.
  always_comb begin
    rd_data = mem[rd_idx];
    if (wr_en1 && (wr_idx1 == rd_idx)) begin
      rd_data = wr_data1;
    end else if (wr_en2 && (wr_idx2 == rd_idx)) begin
      rd_data = wr_data2;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prediction_table.sv
// prediction_table: SP/LHP/GHP predictor tables with registered reads, predictor select and clear sweep.
// Rev 1.0
`default_nettype none

module prediction_table
  import prediction_table_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = 5,
  parameter int ENTRY_W = entry_w(STAT_COUNTER_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PL_stall,
  input  logic                          SP_index1,
  input  logic                          SP_index2,
  input  logic [STAT_COUNTER_WIDTH-1:0] LHP_GHP_index1,
  input  logic [STAT_COUNTER_WIDTH-1:0] LHP_GHP_index2,
  input  logic                          WR_SP_en1,
  input  logic                          WR_SP_en2,
  input  logic                          WR_LHP_en1,
  input  logic                          WR_LHP_en2,
  input  logic                          WR_GHP_en1,
  input  logic                          WR_GHP_en2,
  input  logic [ENTRY_W-1:0]            WR_SP_data1,
  input  logic [ENTRY_W-1:0]            WR_SP_data2,
  input  logic [ENTRY_W-1:0]            WR_LHP_data1,
  input  logic [ENTRY_W-1:0]            WR_LHP_data2,
  input  logic [ENTRY_W-1:0]            WR_GHP_data1,
  input  logic [ENTRY_W-1:0]            WR_GHP_data2,
  input  logic                          rd_en,
  input  logic                          rd_SP_index,
  input  logic [STAT_COUNTER_WIDTH-1:0] rd_LHP_GHP_index,
  input  logic                          clear_req,
  output logic [2:0]                    SP_trend_count,
  output logic [2:0]                    LHP_trend_count,
  output logic [2:0]                    GHP_trend_count,
  output logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count,
  output logic [1:0]                    select,
  output logic                          rd_valid,
  output logic                          busy
);

  localparam int SW = STAT_COUNTER_WIDTH;
  localparam int DEPTH = 2 ** SW;
  localparam logic [ENTRY_W-1:0] INIT_ENTRY = ENTRY_W'(init_entry(SW));
  localparam logic [2:0]         INIT_TR = INIT_ENTRY[ENTRY_W-1 -: 3];
  localparam logic [SW-1:0]      INIT_STAT = INIT_ENTRY[SW-1:0];
  localparam logic [SW-1:0]      PTR_LAST = '1;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;

  logic               clearing;
  logic               sp_clr_all;
  logic               capture;
  logic [ENTRY_W-1:0] sp_rd;
  logic [ENTRY_W-1:0] lhp_rd;
  logic [ENTRY_W-1:0] ghp_rd;
  logic [SW-1:0]      sp_stat;
  logic [SW-1:0]      lhp_stat;
  logic [SW-1:0]      ghp_stat;
  logic [1:0]         select_next;

  assign clearing   = (state == ST_CLEAR);
  assign busy       = clearing;
  assign sp_clr_all = clearing && (ptr == '0);
  assign capture    = rd_en && !PL_stall && !clearing;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          ptr_next   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr == PTR_LAST) begin
          state_next = ST_IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + SW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Writes are locked out for the whole sweep so it always ends in a known state.
  pred_bank #(
    .DEPTH(2), .IDX_W(1), .ENTRY_W(ENTRY_W), .INIT_ENTRY(INIT_ENTRY)
  ) u_sp (
    .clk(clk), .rst(rst),
    .wr_en1(WR_SP_en1 && !clearing), .wr_idx1(SP_index1), .wr_data1(WR_SP_data1),
    .wr_en2(WR_SP_en2 && !clearing), .wr_idx2(SP_index2), .wr_data2(WR_SP_data2),
    .clr_one(1'b0), .clr_idx(1'b0), .clr_all(sp_clr_all),
    .rd_idx(rd_SP_index), .rd_data(sp_rd)
  );

  pred_bank #(
    .DEPTH(DEPTH), .IDX_W(SW), .ENTRY_W(ENTRY_W), .INIT_ENTRY(INIT_ENTRY)
  ) u_lhp (
    .clk(clk), .rst(rst),
    .wr_en1(WR_LHP_en1 && !clearing), .wr_idx1(LHP_GHP_index1), .wr_data1(WR_LHP_data1),
    .wr_en2(WR_LHP_en2 && !clearing), .wr_idx2(LHP_GHP_index2), .wr_data2(WR_LHP_data2),
    .clr_one(clearing), .clr_idx(ptr), .clr_all(1'b0),
    .rd_idx(rd_LHP_GHP_index), .rd_data(lhp_rd)
  );

  pred_bank #(
    .DEPTH(DEPTH), .IDX_W(SW), .ENTRY_W(ENTRY_W), .INIT_ENTRY(INIT_ENTRY)
  ) u_ghp (
    .clk(clk), .rst(rst),
    .wr_en1(WR_GHP_en1 && !clearing), .wr_idx1(LHP_GHP_index1), .wr_data1(WR_GHP_data1),
    .wr_en2(WR_GHP_en2 && !clearing), .wr_idx2(LHP_GHP_index2), .wr_data2(WR_GHP_data2),
    .clr_one(clearing), .clr_idx(ptr), .clr_all(1'b0),
    .rd_idx(rd_LHP_GHP_index), .rd_data(ghp_rd)
  );

  assign sp_stat  = sp_rd[SW-1:0];
  assign lhp_stat = lhp_rd[SW-1:0];
  assign ghp_stat = ghp_rd[SW-1:0];

  // Largest stat wins; ties go to the more global predictor.
  always_comb begin
    select_next = SEL_SP;
    if ((ghp_stat >= lhp_stat) && (ghp_stat >= sp_stat)) begin
      select_next = SEL_GHP;
    end else if (lhp_stat >= sp_stat) begin
      select_next = SEL_LHP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      SP_trend_count  <= INIT_TR;
      LHP_trend_count <= INIT_TR;
      GHP_trend_count <= INIT_TR;
      SP_stat_count   <= INIT_STAT;
      LHP_stat_count  <= INIT_STAT;
      GHP_stat_count  <= INIT_STAT;
      select          <= SEL_GHP;
      rd_valid        <= 1'b0;
    end else if (clearing) begin
      rd_valid <= 1'b0;
    end else if (!PL_stall) begin
      rd_valid <= rd_en;
      if (capture) begin
        SP_trend_count  <= sp_rd[ENTRY_W-1 -: 3];
        LHP_trend_count <= lhp_rd[ENTRY_W-1 -: 3];
        GHP_trend_count <= ghp_rd[ENTRY_W-1 -: 3];
        SP_stat_count   <= sp_stat;
        LHP_stat_count  <= lhp_stat;
        GHP_stat_count  <= ghp_stat;
        select          <= select_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prediction_table.sv
// tb_prediction_table: vector table plus clear/reset sequences, checked through an expectation queue.
// Rev 1.0
`default_nettype none

module tb_prediction_table;

  localparam int T_NONE = 0;
  localparam int T_SP   = 1;
  localparam int T_LHP  = 2;
  localparam int T_GHP  = 3;
  localparam int NV     = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, PL_stall, SP_index1, SP_index2;
  logic [4:0] LHP_GHP_index1, LHP_GHP_index2;
  logic       WR_SP_en1, WR_SP_en2, WR_LHP_en1, WR_LHP_en2, WR_GHP_en1, WR_GHP_en2;
  logic [7:0] WR_SP_data1, WR_SP_data2, WR_LHP_data1, WR_LHP_data2, WR_GHP_data1, WR_GHP_data2;
  logic       rd_en, rd_SP_index, clear_req;
  logic [4:0] rd_LHP_GHP_index;
  logic [2:0] SP_trend_count, LHP_trend_count, GHP_trend_count;
  logic [4:0] SP_stat_count, LHP_stat_count, GHP_stat_count;
  logic [1:0] select;
  logic       rd_valid, busy;

  prediction_table #(.STAT_COUNTER_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .PL_stall(PL_stall),
    .SP_index1(SP_index1), .SP_index2(SP_index2),
    .LHP_GHP_index1(LHP_GHP_index1), .LHP_GHP_index2(LHP_GHP_index2),
    .WR_SP_en1(WR_SP_en1), .WR_SP_en2(WR_SP_en2),
    .WR_LHP_en1(WR_LHP_en1), .WR_LHP_en2(WR_LHP_en2),
    .WR_GHP_en1(WR_GHP_en1), .WR_GHP_en2(WR_GHP_en2),
    .WR_SP_data1(WR_SP_data1), .WR_SP_data2(WR_SP_data2),
    .WR_LHP_data1(WR_LHP_data1), .WR_LHP_data2(WR_LHP_data2),
    .WR_GHP_data1(WR_GHP_data1), .WR_GHP_data2(WR_GHP_data2),
    .rd_en(rd_en), .rd_SP_index(rd_SP_index), .rd_LHP_GHP_index(rd_LHP_GHP_index),
    .clear_req(clear_req),
    .SP_trend_count(SP_trend_count), .LHP_trend_count(LHP_trend_count),
    .GHP_trend_count(GHP_trend_count),
    .SP_stat_count(SP_stat_count), .LHP_stat_count(LHP_stat_count),
    .GHP_stat_count(GHP_stat_count),
    .select(select), .rd_valid(rd_valid), .busy(busy)
  );

  typedef struct {
    int         w1_tab;
    logic [4:0] w1_idx;
    logic [7:0] w1_dat;
    int         w2_tab;
    logic [4:0] w2_idx;
    logic [7:0] w2_dat;
    logic       rd;
    logic       stall;
    logic       rsp;
    logic [4:0] ridx;
    logic [27:0] exp_out;
  } vec_t;

  vec_t        vecs [NV];
  logic [27:0] exp_q [$];
  string       name_q [$];
  int          n_vec = 0;
  int          n_miss = 0;

  // Bundle order: {SP trend, SP stat, LHP trend, LHP stat, GHP trend, GHP stat, select, rd_valid, busy}
  function automatic logic [27:0] pk(input logic [2:0] st, input logic [4:0] ss,
                                     input logic [2:0] lt, input logic [4:0] ls,
                                     input logic [2:0] gt, input logic [4:0] gs,
                                     input logic [1:0] sel, input logic v, input logic b);
    return {st, ss, lt, ls, gt, gs, sel, v, b};
  endfunction

  function automatic vec_t mk(input int t1, input logic [4:0] i1, input logic [7:0] d1,
                              input int t2, input logic [4:0] i2, input logic [7:0] d2,
                              input logic r, input logic s, input logic rsp, input logic [4:0] ri,
                              input logic [27:0] e);
    vec_t v;
    v.w1_tab = t1; v.w1_idx = i1; v.w1_dat = d1;
    v.w2_tab = t2; v.w2_idx = i2; v.w2_dat = d2;
    v.rd = r; v.stall = s; v.rsp = rsp; v.ridx = ri; v.exp_out = e;
    return v;
  endfunction

  task automatic idle();
    PL_stall = 1'b0; SP_index1 = 1'b0; SP_index2 = 1'b0;
    LHP_GHP_index1 = 5'd0; LHP_GHP_index2 = 5'd0;
    WR_SP_en1 = 1'b0; WR_SP_en2 = 1'b0; WR_LHP_en1 = 1'b0; WR_LHP_en2 = 1'b0;
    WR_GHP_en1 = 1'b0; WR_GHP_en2 = 1'b0;
    WR_SP_data1 = 8'h0; WR_SP_data2 = 8'h0; WR_LHP_data1 = 8'h0; WR_LHP_data2 = 8'h0;
    WR_GHP_data1 = 8'h0; WR_GHP_data2 = 8'h0;
    rd_en = 1'b0; rd_SP_index = 1'b0; rd_LHP_GHP_index = 5'd0; clear_req = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    idle();
    case (v.w1_tab)
      T_SP:  begin WR_SP_en1 = 1'b1;  SP_index1 = v.w1_idx[0];   WR_SP_data1 = v.w1_dat;  end
      T_LHP: begin WR_LHP_en1 = 1'b1; LHP_GHP_index1 = v.w1_idx; WR_LHP_data1 = v.w1_dat; end
      T_GHP: begin WR_GHP_en1 = 1'b1; LHP_GHP_index1 = v.w1_idx; WR_GHP_data1 = v.w1_dat; end
      default: ;
    endcase
    case (v.w2_tab)
      T_SP:  begin WR_SP_en2 = 1'b1;  SP_index2 = v.w2_idx[0];   WR_SP_data2 = v.w2_dat;  end
      T_LHP: begin WR_LHP_en2 = 1'b1; LHP_GHP_index2 = v.w2_idx; WR_LHP_data2 = v.w2_dat; end
      T_GHP: begin WR_GHP_en2 = 1'b1; LHP_GHP_index2 = v.w2_idx; WR_GHP_data2 = v.w2_dat; end
      default: ;
    endcase
    rd_en = v.rd; PL_stall = v.stall; rd_SP_index = v.rsp; rd_LHP_GHP_index = v.ridx;
  endtask

  task automatic expect_out(input string nm, input logic [27:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One clock; any pending expectation is compared 1 time unit after the edge.
  task automatic step();
    logic [27:0] act;
    logic [27:0] e;
    string       nm;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {SP_trend_count, SP_stat_count, LHP_trend_count, LHP_stat_count,
             GHP_trend_count, GHP_stat_count, select, rd_valid, busy};
      n_vec++;
      if (act !== e) begin
        n_miss++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  endtask

  logic [27:0] held;

  initial begin
    idle();
    rst = 1'b1;
    step();
    expect_out("reset", pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd16, 2'b10, 1'b0, 1'b0));
    step();
    rst = 1'b0;

    vecs[0]  = mk(T_NONE, 5'd0, 8'h00, T_NONE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd7,
                  pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd16, 2'b10, 1'b1, 1'b0));
    vecs[1]  = mk(T_LHP, 5'd3, 8'hBF, T_LHP, 5'd3, 8'h01, 1'b0, 1'b0, 1'b0, 5'd0,
                  pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd16, 2'b10, 1'b0, 1'b0));
    vecs[2]  = mk(T_NONE, 5'd0, 8'h00, T_NONE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd3,
                  pk(3'd4, 5'd16, 3'd5, 5'd31, 3'd4, 5'd16, 2'b01, 1'b1, 1'b0));
    vecs[3]  = mk(T_GHP, 5'd9, 8'h9E, T_NONE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd9,
                  pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd30, 2'b10, 1'b1, 1'b0));
    vecs[4]  = mk(T_LHP, 5'd5, 8'h2A, T_LHP, 5'd6, 8'hE3, 1'b0, 1'b0, 1'b0, 5'd0,
                  pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd30, 2'b10, 1'b0, 1'b0));
    vecs[5]  = mk(T_NONE, 5'd0, 8'h00, T_NONE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd5,
                  pk(3'd4, 5'd16, 3'd1, 5'd10, 3'd4, 5'd16, 2'b10, 1'b1, 1'b0));
    vecs[6]  = mk(T_NONE, 5'd0, 8'h00, T_NONE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd6,
                  pk(3'd4, 5'd16, 3'd7, 5'd3, 3'd4, 5'd16, 2'b10, 1'b1, 1'b0));
    vecs[7]  = mk(T_SP, 5'd1, 8'h7F, T_SP, 5'd1, 8'h00, 1'b1, 1'b0, 1'b1, 5'd3,
                  pk(3'd3, 5'd31, 3'd5, 5'd31, 3'd4, 5'd16, 2'b01, 1'b1, 1'b0));
    vecs[8]  = mk(T_NONE, 5'd0, 8'h00, T_NONE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd9,
                  pk(3'd3, 5'd31, 3'd4, 5'd16, 3'd4, 5'd30, 2'b00, 1'b1, 1'b0));
    vecs[9]  = mk(T_NONE, 5'd0, 8'h00, T_LHP, 5'd9, 8'hDF, 1'b1, 1'b0, 1'b1, 5'd9,
                  pk(3'd3, 5'd31, 3'd6, 5'd31, 3'd4, 5'd30, 2'b01, 1'b1, 1'b0));
    vecs[10] = mk(T_GHP, 5'd20, 8'hFF, T_NONE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd20,
                  pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd7, 5'd31, 2'b10, 1'b1, 1'b0));
    vecs[11] = mk(T_GHP, 5'd3, 8'h5F, T_NONE, 5'd0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd3,
                  pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd7, 5'd31, 2'b10, 1'b1, 1'b0));
    vecs[12] = mk(T_NONE, 5'd0, 8'h00, T_NONE, 5'd0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd6,
                  pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd7, 5'd31, 2'b10, 1'b1, 1'b0));
    vecs[13] = mk(T_NONE, 5'd0, 8'h00, T_NONE, 5'd0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd9,
                  pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd7, 5'd31, 2'b10, 1'b1, 1'b0));
    vecs[14] = mk(T_NONE, 5'd0, 8'h00, T_NONE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd3,
                  pk(3'd4, 5'd16, 3'd5, 5'd31, 3'd2, 5'd31, 2'b10, 1'b1, 1'b0));
    vecs[15] = mk(T_GHP, 5'd9, 8'h00, T_GHP, 5'd9, 8'hFF, 1'b1, 1'b0, 1'b0, 5'd9,
                  pk(3'd4, 5'd16, 3'd6, 5'd31, 3'd0, 5'd0, 2'b01, 1'b1, 1'b0));
    vecs[16] = mk(T_NONE, 5'd0, 8'h00, T_NONE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd9,
                  pk(3'd4, 5'd16, 3'd6, 5'd31, 3'd0, 5'd0, 2'b01, 1'b1, 1'b0));

    for (int i = 0; i < NV; i++) begin
      drive_vec(vecs[i]);
      expect_out($sformatf("vec%0d", i), vecs[i].exp_out);
      step();
    end

    // Clear sweep: prefill, start with a same-cycle write, then locked-out writes for 31 cycles.
    held = pk(3'd4, 5'd16, 3'd6, 5'd31, 3'd0, 5'd0, 2'b01, 1'b0, 1'b0);
    idle();
    WR_LHP_en1 = 1'b1; LHP_GHP_index1 = 5'd0;  WR_LHP_data1 = 8'hFF;
    WR_LHP_en2 = 1'b1; LHP_GHP_index2 = 5'd31; WR_LHP_data2 = 8'hFF;
    expect_out("clr_prefill", held);
    step();
    idle();
    clear_req = 1'b1;
    WR_GHP_en1 = 1'b1; LHP_GHP_index1 = 5'd1; WR_GHP_data1 = 8'hFF;
    expect_out("clr_start", held | 28'd1);
    step();
    for (int c = 1; c < 32; c++) begin
      idle();
      clear_req = 1'b1;
      WR_LHP_en1 = 1'b1; LHP_GHP_index1 = 5'd0; WR_LHP_data1 = 8'hFF;
      WR_SP_en1 = 1'b1; SP_index1 = 1'b1; WR_SP_data1 = 8'hFF;
      rd_en = 1'b1;
      expect_out($sformatf("clr_busy%0d", c), held | 28'd1);
      step();
    end
    idle();
    WR_LHP_en1 = 1'b1; LHP_GHP_index1 = 5'd0; WR_LHP_data1 = 8'hFF;
    expect_out("clr_done", held);
    step();

    idle(); rd_en = 1'b1; rd_SP_index = 1'b1; rd_LHP_GHP_index = 5'd0;
    expect_out("post_clr_idx0", pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd16, 2'b10, 1'b1, 1'b0));
    step();
    idle(); rd_en = 1'b1; rd_LHP_GHP_index = 5'd31;
    expect_out("post_clr_idx31", pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd16, 2'b10, 1'b1, 1'b0));
    step();
    idle(); rd_en = 1'b1; rd_LHP_GHP_index = 5'd1;
    expect_out("post_clr_idx1", pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd16, 2'b10, 1'b1, 1'b0));
    step();
    idle(); rd_en = 1'b1; rd_SP_index = 1'b1; rd_LHP_GHP_index = 5'd9;
    expect_out("post_clr_idx9", pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd16, 2'b10, 1'b1, 1'b0));
    step();

    // Reset in the middle of a sweep.
    held = pk(3'd4, 5'd16, 3'd7, 5'd31, 3'd4, 5'd16, 2'b01, 1'b0, 1'b0);
    idle();
    WR_LHP_en1 = 1'b1; LHP_GHP_index1 = 5'd30; WR_LHP_data1 = 8'hFF;
    rd_en = 1'b1; rd_LHP_GHP_index = 5'd30;
    expect_out("rst_pre", held | 28'd2);
    step();
    idle(); clear_req = 1'b1;
    expect_out("rst_clr_start", held | 28'd1);
    step();
    for (int c = 1; c < 10; c++) begin
      idle();
      expect_out($sformatf("rst_sweep%0d", c), held | 28'd1);
      step();
    end
    idle();
    rst = 1'b1; PL_stall = 1'b1; rd_en = 1'b1; rd_LHP_GHP_index = 5'd30;
    expect_out("rst_abort", pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd16, 2'b10, 1'b0, 1'b0));
    step();
    rst = 1'b0;
    idle(); rd_en = 1'b1; rd_LHP_GHP_index = 5'd30;
    expect_out("rst_after_read", pk(3'd4, 5'd16, 3'd4, 5'd16, 3'd4, 5'd16, 2'b10, 1'b1, 1'b0));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prediction_table.md
PREDICTION_TABLE -- requirements
Module: prediction_table

Interface
REQ-001 Parameter: STAT_COUNTER_WIDTH, default 5, width of one stat counter; LHP/GHP depth = 2**STAT_COUNTER_WIDTH.
REQ-002 Parameter: ENTRY_W, default 3+STAT_COUNTER_WIDTH, entry layout {trend[2:0], stat[STAT_COUNTER_WIDTH-1:0]}.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 PL_stall  in  1  pipeline stall; holds read outputs.
REQ-006 SP_index1, SP_index2  in  1 each  SP entry select for write ports 1/2.
REQ-007 LHP_GHP_index1, LHP_GHP_index2  in  STAT_COUNTER_WIDTH each  LHP/GHP entry select for write ports 1/2.
REQ-008 WR_SP_en1/2, WR_LHP_en1/2, WR_GHP_en1/2  in  1 each  per-table write enables.
REQ-009 WR_SP_data1/2, WR_LHP_data1/2, WR_GHP_data1/2  in  ENTRY_W each  write data.
REQ-010 rd_en  in  1  read request; rd_SP_index  in  1; rd_LHP_GHP_index  in  STAT_COUNTER_WIDTH.
REQ-011 clear_req  in  1  start table reinitialisation sweep.
REQ-012 SP/LHP/GHP_trend_count  out  3 each; SP/LHP/GHP_stat_count  out  STAT_COUNTER_WIDTH each  registered read data.
REQ-013 select  out  2  chosen predictor: 00 SP, 01 LHP, 10 GHP; rd_valid  out  1; busy  out  1.

Function
REQ-014 Storage: SP 2 entries, LHP and GHP 2**STAT_COUNTER_WIDTH entries each; init value INIT_ENTRY = trend 3'd4, stat 2**(STAT_COUNTER_WIDTH-1).
REQ-015 Writes commit at the clock edge when enabled, independent of PL_stall.
REQ-016 Both ports, same table, same index, same cycle: port 1 written, port 2 dropped; different indices: both written.
REQ-017 Read latency 1 cycle: at edge with rd_en=1, PL_stall=0, busy=0, outputs capture entries at rd indices and rd_valid<=1.
REQ-018 Bypass: a write in the capture cycle to the read index of that table is returned instead of stored data (port 1 over port 2).
REQ-019 PL_stall=1: all read outputs, select and rd_valid hold; writes still commit.
REQ-020 rd_en=0 with PL_stall=0: rd_valid<=0, data outputs hold.
REQ-021 select registered with data: largest stat of the three captured values; ties resolved GHP > LHP > SP.
REQ-022 FSM states IDLE, CLEAR; IDLE->CLEAR on clear_req=1; CLEAR->IDLE after pointer reaches 2**STAT_COUNTER_WIDTH-1.
REQ-023 CLEAR: each cycle LHP[ptr], GHP[ptr] <= INIT_ENTRY, ptr increments from 0; both SP entries <= INIT_ENTRY in first CLEAR cycle; sweep takes exactly 2**STAT_COUNTER_WIDTH cycles.
REQ-024 CLEAR: busy=1, all write enables ignored, rd_valid<=0, data outputs hold; clear_req ignored.
REQ-025 clear_req and writes in same IDLE cycle: writes commit, sweep then overwrites them.
REQ-026 Pointer width STAT_COUNTER_WIDTH, no wrap beyond last index; all widths exact, no truncation.

Reset
REQ-027 rst=1: all entries <= INIT_ENTRY, FSM IDLE, ptr 0, busy 0, rd_valid 0, trend outputs 3'd4, stat outputs 2**(STAT_COUNTER_WIDTH-1), select 2'b10.
REQ-028 rst overrides writes, reads, stall and an in-progress sweep in the same cycle; sweep aborts.

Structure
REQ-029 Shared package holds ENTRY_W derivation, INIT_ENTRY, select encodings, FSM state enum.
REQ-030 One sub-module, pred_bank (parameterised depth, 2 write ports with port-1 priority, 1 read index, bypass), instantiated for SP, LHP, GHP; select logic and FSM in top.

Verification
REQ-031 After rst, rd_en=1 index 7 -> next cycle rd_valid=1, all trend=4, stat=16, select=10.
REQ-032 WR_LHP_en1=1 idx 3 data 8'hBF plus WR_LHP_en2=1 idx 3 data 8'h01, then read idx 3 -> LHP trend=5, stat=31, select=01.
REQ-033 Write GHP idx 9 data 8'h9E while rd_en=1 idx 9 same cycle -> GHP stat=30 next cycle (bypass).
REQ-034 PL_stall=1 for 3 cycles with rd_en=1, new index -> outputs, select, rd_valid unchanged.
REQ-035 Fill LHP idx 0 and 31 with 8'hFF, pulse clear_req -> busy=1 for 32 cycles, writes ignored, then reads idx 0 and 31 return trend 4, stat 16.
REQ-036 rst asserted at sweep cycle 10 -> busy=0 next cycle, all entries INIT_ENTRY.
